// File: rtl/reg_file_sb.sv
// reg_file_sb: integer register file with a per-register pending-write
// scoreboard for the pipelined core. Two combinational read ports, one
// synchronous write port, register 0 reads as zero.
// Optional macro RF_BYPASS_EN: same-cycle write-to-read forwarding of data
// and of the busy release on the read ports.
module reg_file_sb #(
    parameter int XLEN = 32,
    parameter int NREG = 32,
    parameter int AW   = 5,
    parameter int PW   = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [AW-1:0]   rs1_addr,
    input  logic [AW-1:0]   rs2_addr,
    output logic [XLEN-1:0] rs1_data,
    output logic [XLEN-1:0] rs2_data,
    output logic            rs1_busy,
    output logic            rs2_busy,
    input  logic            wr_en,
    input  logic [AW-1:0]   wr_addr,
    input  logic [XLEN-1:0] wr_data,
    input  logic            iss_valid,
    input  logic [AW-1:0]   iss_rd,
    output logic            iss_ready,
    output logic            pend_any
);

    localparam logic [PW-1:0] CNT_MAX = '1;
    localparam logic [PW-1:0] CNT_ONE = PW'(1);

    logic [XLEN-1:0] regs [NREG];
    logic [PW-1:0]   cnt  [NREG];
    logic [NREG-1:0] inc_vec;
    logic [NREG-1:0] dec_vec;

    // Register storage; entry 0 is only ever reset and never written
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < NREG; r++) begin
                regs[r] <= '0;
            end
        end else begin
            for (int r = 1; r < NREG; r++) begin
                if (wr_en && (wr_addr == AW'(r))) begin
                    regs[r] <= wr_data;
                end
            end
        end
    end

    // Issue is refused only when the destination counter is saturated
    always_comb begin
        iss_ready = 1'b1;
        if ((iss_rd != '0) && (cnt[iss_rd] == CNT_MAX)) begin
            iss_ready = 1'b0;
        end
    end

    // Per-register reserve/release requests; register 0 never participates
    always_comb begin
        inc_vec = '0;
        dec_vec = '0;
        for (int r = 1; r < NREG; r++) begin
            inc_vec[r] = iss_valid && iss_ready && (iss_rd == AW'(r));
            dec_vec[r] = wr_en && (wr_addr == AW'(r)) && (cnt[r] != '0);
        end
    end

    // Pending-write counters; a simultaneous reserve and release cancel out
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < NREG; r++) begin
                cnt[r] <= '0;
            end
        end else begin
            for (int r = 1; r < NREG; r++) begin
                if (inc_vec[r] && !dec_vec[r]) begin
                    cnt[r] <= cnt[r] + CNT_ONE;
                end else if (dec_vec[r] && !inc_vec[r]) begin
                    cnt[r] <= cnt[r] - CNT_ONE;
                end
            end
        end
    end

    // Global pending flag for drain/flush logic in decode
    always_comb begin
        pend_any = 1'b0;
        for (int r = 0; r < NREG; r++) begin
            if (cnt[r] != '0) begin
                pend_any = 1'b1;
            end
        end
    end

    // Read port A data and hazard flag
    always_comb begin
        rs1_data = '0;
        rs1_busy = 1'b0;
        if (rs1_addr != '0) begin
            rs1_data = regs[rs1_addr];
            rs1_busy = (cnt[rs1_addr] != '0);
`ifdef RF_BYPASS_EN
            if (wr_en && (wr_addr == rs1_addr)) begin
                rs1_data = wr_data;
                if (cnt[rs1_addr] == CNT_ONE) begin
                    rs1_busy = 1'b0;
                end
            end
`endif
        end
    end

    // Read port B data and hazard flag
    always_comb begin
        rs2_data = '0;
        rs2_busy = 1'b0;
        if (rs2_addr != '0) begin
            rs2_data = regs[rs2_addr];
            rs2_busy = (cnt[rs2_addr] != '0);
`ifdef RF_BYPASS_EN
            if (wr_en && (wr_addr == rs2_addr)) begin
                rs2_data = wr_data;
                if (cnt[rs2_addr] == CNT_ONE) begin
                    rs2_busy = 1'b0;
                end
            end
`endif
        end
    end

endmodule

// File: tb/tb_reg_file_sb.sv
// tb_reg_file_sb: directed and randomized checks of reg_file_sb against a
// behavioural model of registers and outstanding-write counts.
module tb_reg_file_sb;

    localparam int XLEN    = 32;
    localparam int NREG    = 32;
    localparam int AW      = 5;
    localparam int PW      = 2;
    localparam int CNT_MAX = (1 << PW) - 1;

    logic            clk;
    logic            rst_n;
    logic [AW-1:0]   rs1_addr;
    logic [AW-1:0]   rs2_addr;
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;
    logic            rs1_busy;
    logic            rs2_busy;
    logic            wr_en;
    logic [AW-1:0]   wr_addr;
    logic [XLEN-1:0] wr_data;
    logic            iss_valid;
    logic [AW-1:0]   iss_rd;
    logic            iss_ready;
    logic            pend_any;

    int test_count = 0;
    int fail_count = 0;

    logic [XLEN-1:0] model_regs [NREG];
    int              model_cnt  [NREG];

    reg_file_sb #(.XLEN(XLEN), .NREG(NREG), .AW(AW), .PW(PW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .rs1_addr  (rs1_addr),
        .rs2_addr  (rs2_addr),
        .rs1_data  (rs1_data),
        .rs2_data  (rs2_data),
        .rs1_busy  (rs1_busy),
        .rs2_busy  (rs2_busy),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .iss_valid (iss_valid),
        .iss_rd    (iss_rd),
        .iss_ready (iss_ready),
        .pend_any  (pend_any)
    );

    // Free-running 10 ns clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [XLEN-1:0] observed,
                               input logic [XLEN-1:0] expected);
        test_count++;
        assert (observed === expected) else begin
            fail_count++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic we, input logic [AW-1:0] wa,
                                 input logic [XLEN-1:0] wd, input logic iv,
                                 input logic [AW-1:0] ird, input logic [AW-1:0] a1,
                                 input logic [AW-1:0] a2);
        wr_en     = we;
        wr_addr   = wa;
        wr_data   = wd;
        iss_valid = iv;
        iss_rd    = ird;
        rs1_addr  = a1;
        rs2_addr  = a2;
    endtask

    task automatic modelReset();
        for (int r = 0; r < NREG; r++) begin
            model_regs[r] = '0;
            model_cnt[r]  = 0;
        end
    endtask

    function automatic logic [XLEN-1:0] expData(input logic [AW-1:0] a);
        if (a == 0) return '0;
`ifdef RF_BYPASS_EN
        if (wr_en && wr_addr == a) return wr_data;
`endif
        return model_regs[a];
    endfunction

    function automatic logic [XLEN-1:0] expBusy(input logic [AW-1:0] a);
        if (a == 0 || model_cnt[a] == 0) return '0;
`ifdef RF_BYPASS_EN
        if (wr_en && wr_addr == a && model_cnt[a] == 1) return '0;
`endif
        return 1;
    endfunction

    function automatic logic [XLEN-1:0] expReady();
        if (iss_rd != 0 && model_cnt[iss_rd] == CNT_MAX) return '0;
        return 1;
    endfunction

    function automatic logic [XLEN-1:0] expPend();
        foreach (model_cnt[r]) if (model_cnt[r] != 0) return 1;
        return '0;
    endfunction

    task automatic compareAll();
        checkOutput("rs1_data", rs1_data, expData(rs1_addr));
        checkOutput("rs2_data", rs2_data, expData(rs2_addr));
        checkOutput("rs1_busy", {31'b0, rs1_busy}, expBusy(rs1_addr));
        checkOutput("rs2_busy", {31'b0, rs2_busy}, expBusy(rs2_addr));
        checkOutput("iss_ready", {31'b0, iss_ready}, expReady());
        checkOutput("pend_any", {31'b0, pend_any}, expPend());
    endtask

    // Advance the model by one clock edge using the inputs held across it
    task automatic modelEdge();
        bit take;
        bit rel;
        take = iss_valid && iss_rd != 0 && model_cnt[iss_rd] < CNT_MAX;
        rel  = wr_en && wr_addr != 0 && model_cnt[wr_addr] > 0;
        if (wr_en && wr_addr != 0) model_regs[wr_addr] = wr_data;
        if (take) model_cnt[iss_rd] = model_cnt[iss_rd] + 1;
        if (rel)  model_cnt[wr_addr] = model_cnt[wr_addr] - 1;
    endtask

    // Must be entered between posedge+1 and the following negedge
    task automatic step();
        @(negedge clk);
        compareAll();
        @(posedge clk);
        modelEdge();
        #1;
    endtask

    task automatic idle(input logic [AW-1:0] a1, input logic [AW-1:0] a2);
        applyStimulus(1'b0, '0, '0, 1'b0, '0, a1, a2);
    endtask

    // Directed scenarios followed by a randomized phase
    initial begin
        logic [XLEN-1:0] exp_fwd;
        modelReset();
        idle('0, '0);
        rst_n = 1'b0;
        #12;
        checkOutput("rst_iss_ready", {31'b0, iss_ready}, 1);
        checkOutput("rst_pend_any", {31'b0, pend_any}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int a = 0; a < NREG; a++) begin
            idle(AW'(a), AW'(NREG - 1 - a));
            #1;
            checkOutput("reset_rd1", rs1_data, 0);
            checkOutput("reset_rd2", rs2_data, 0);
            checkOutput("reset_busy", {30'b0, rs1_busy, rs2_busy}, 0);
        end
        checkOutput("reset_ready", {31'b0, iss_ready}, 1);
        checkOutput("reset_pend", {31'b0, pend_any}, 0);
        @(posedge clk);
        #1;

        // Writes to register 0 are discarded
        applyStimulus(1'b1, 5'd0, 32'hDEADBEEF, 1'b0, '0, 5'd0, 5'd0);
        step();
        idle(5'd0, 5'd5);
        #1;
        checkOutput("r0_after_write", rs1_data, 0);
        applyStimulus(1'b1, 5'd5, 32'h12345678, 1'b0, '0, 5'd0, 5'd5);
        step();
        idle(5'd0, 5'd5);
        #1;
        checkOutput("r5_next_cycle", rs2_data, 32'h12345678);
        step();

        // Fill counter of r7 to saturation, then drain it
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, '0, '0, 1'b1, 5'd7, 5'd7, 5'd0);
            step();
        end
        applyStimulus(1'b0, '0, '0, 1'b1, 5'd7, 5'd7, 5'd0);
        #1;
        checkOutput("r7_saturated_ready", {31'b0, iss_ready}, 0);
        step();
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 5'd7, 32'h700 + XLEN'(i), 1'b0, '0, 5'd7, 5'd0);
            step();
        end
        idle(5'd7, 5'd0);
        #1;
        checkOutput("r7_busy_drained", {31'b0, rs1_busy}, 0);
        checkOutput("pend_after_drain", {31'b0, pend_any}, 0);
        checkOutput("r7_last_data", rs1_data, 32'h702);
        step();

        // Reserve and release r9 on the same edge
        applyStimulus(1'b0, '0, '0, 1'b1, 5'd9, 5'd9, 5'd0);
        step();
        applyStimulus(1'b1, 5'd9, 32'h0000A5A5, 1'b1, 5'd9, 5'd9, 5'd0);
        step();
        idle(5'd9, 5'd0);
        #1;
        checkOutput("r9_busy_held", {31'b0, rs1_busy}, 1);
        checkOutput("r9_data", rs1_data, 32'h0000A5A5);
        applyStimulus(1'b1, 5'd9, 32'h0000A5A6, 1'b0, '0, 5'd9, 5'd0);
        step();

        // Same-cycle write visibility on r3
        applyStimulus(1'b1, 5'd3, 32'h11, 1'b0, '0, 5'd0, 5'd0);
        step();
        applyStimulus(1'b1, 5'd3, 32'h22, 1'b0, '0, 5'd3, 5'd0);
        #1;
`ifdef RF_BYPASS_EN
        exp_fwd = 32'h22;
`else
        exp_fwd = 32'h11;
`endif
        checkOutput("r3_same_cycle", rs1_data, exp_fwd);
        step();
        idle(5'd3, 5'd0);
        #1;
        checkOutput("r3_next_cycle", rs1_data, 32'h22);

        // Asynchronous reset while r4 has two reservations
        applyStimulus(1'b1, 5'd4, 32'h44, 1'b1, 5'd4, 5'd4, 5'd0);
        step();
        applyStimulus(1'b0, '0, '0, 1'b1, 5'd4, 5'd4, 5'd0);
        step();
        idle(5'd4, 5'd4);
        #1;
        checkOutput("r4_busy_before_rst", {31'b0, rs1_busy}, 1);
        checkOutput("r4_data_before_rst", rs1_data, 32'h44);
        rst_n = 1'b0;
        #1;
        checkOutput("r4_busy_in_rst", {31'b0, rs1_busy}, 0);
        checkOutput("r4_data_in_rst", rs1_data, 0);
        checkOutput("pend_in_rst", {31'b0, pend_any}, 0);
        modelReset();
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checkOutput("r4_busy_after_rst", {31'b0, rs1_busy}, 0);
        checkOutput("r4_data_after_rst", rs2_data, 0);
        @(posedge clk);
        #1;
        step();

        // Randomized traffic concentrated on a few registers
        for (int i = 0; i < 400; i++) begin
            applyStimulus(1'($urandom_range(0, 1)), AW'($urandom_range(0, 7)), $urandom,
                          1'($urandom_range(0, 1)), AW'($urandom_range(0, 7)),
                          AW'($urandom_range(0, 7)), AW'($urandom_range(0, NREG - 1)));
            step();
        end

        $display("[TB] %0d tests run, %0d failed", test_count, fail_count);
        $finish;
    end

endmodule

// File: doc/reg_file_sb.md
Name: reg_file_sb

Overview:
- Parametrised integer register file for the pipelined core, successor to the single-cycle register file.
- Two asynchronous read ports and one synchronous write port, with register 0 hard-wired to zero.
- Each register has a pending-write counter (scoreboard) used by decode to detect RAW hazards and stall issue.
- Sits between decode/issue (read, reserve) and writeback (write, release).

Parameters:
- XLEN, 32, data width of each register.
- NREG, 32, number of architectural registers (power of two, >= 2).
- AW, 5, address width; must equal log2(NREG).
- PW, 2, pending-counter width per register; max outstanding writes per register = 2^PW - 1.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- rs1_addr  in  AW  read port A address.
- rs2_addr  in  AW  read port B address.
- rs1_data  out  XLEN  read port A data.
- rs2_data  out  XLEN  read port B data.
- rs1_busy  out  1  port A register has an outstanding write.
- rs2_busy  out  1  port B register has an outstanding write.
- wr_en  in  1  writeback valid.
- wr_addr  in  AW  writeback destination.
- wr_data  in  XLEN  writeback data.
- iss_valid  in  1  instruction issued this cycle with a destination register.
- iss_rd  in  AW  destination reserved by the issue.
- iss_ready  out  1  issue may reserve iss_rd (counter not saturated).
- pend_any  out  1  at least one counter is non-zero.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - All registers cleared to 0 and all counters cleared to 0.
  - rsX_data=0, rsX_busy=0, iss_ready=1, pend_any=0.
  - Reset asserted mid-operation discards all pending reservations immediately.
- Reads are combinational:
  - rsX_data = 0 when rsX_addr==0, otherwise the stored register value.
- Write:
  - On a rising edge with wr_en=1 and wr_addr!=0, register[wr_addr] <= wr_data.
  - Writes to address 0 are ignored; register 0 stays 0 and its counter stays 0.
- Scoreboard, per register r != 0, at each rising edge:
  - inc = iss_valid & iss_ready & (iss_rd==r).
  - dec = wr_en & (wr_addr==r) & (cnt[r]!=0).
  - inc & !dec: cnt+1. dec & !inc: cnt-1. Both asserted: unchanged.
  - wr_en to a register whose cnt==0 updates the data but leaves cnt at 0 (no underflow).
  - iss_valid with iss_rd==0 is accepted; no counter change.
- iss_ready:
  - 0 when iss_rd!=0 and cnt[iss_rd] == 2^PW-1, else 1. Combinational.
  - iss_valid while iss_ready=0 is ignored; the issuer must hold the instruction.
- rsX_busy:
  - (rsX_addr!=0) & (cnt[rsX_addr]!=0), modified by RF_BYPASS_EN (see below).
  - Combinational; no dependence on iss_* in the same cycle.
- pend_any = OR of all counters != 0.
- Latency:
  - Written data becomes readable the cycle after the write edge.
  - Reservations and releases are visible in rsX_busy the cycle after the edge.

Optional Feature:
- Macro: RF_BYPASS_EN.
- Defined:
  - Same-cycle write-to-read forwarding. If wr_en=1, wr_addr!=0 and rsX_addr==wr_addr, then rsX_data=wr_data.
  - rsX_busy is deasserted when cnt[rsX_addr]==1 and that same write releases it.
- Not defined:
  - rsX_data always shows the stored value; a same-cycle write is visible only from the next cycle.
  - rsX_busy reflects the counter only.

Test Plan:
- Reset, then read all 32 addresses -> every rsX_data=0, busy=0, iss_ready=1, pend_any=0.
- wr_en=1, wr_addr=0, wr_data=0xDEADBEEF, then rs1_addr=0 -> rs1_data=0 permanently; write wr_addr=5, 0x12345678 -> rs2_data=0x12345678 one cycle later.
- iss_valid, iss_rd=7 for 3 cycles (PW=2) -> cnt=3, iss_ready=0 on rd 7; a 4th issue is ignored; three writebacks to 7 -> rs1_busy (addr 7) clears after the third; pend_any=0.
- Same cycle iss_valid/iss_rd=9 and wr_en/wr_addr=9 with cnt[9]=1 -> cnt stays 1, rs1_busy stays 1, register 9 updated.
- RF_BYPASS_EN defined: reg 3 holds 0x11, wr 3 <= 0x22 with rs1_addr=3 in the same cycle -> rs1_data=0x22 in that cycle; not defined -> 0x11 in that cycle, then 0x22.
- cnt[4]=2, assert rst_n=0 between edges -> counters and data clear immediately; after release rs1_busy=0 and rs1_data=0 for addr 4.
